// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access sequencer.
package csr_pkg;

  typedef enum logic [1:0] {
    OpRead = 2'b00,
    OpRw   = 2'b01,
    OpRs   = 2'b10,
    OpRc   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } ctrl_state_t;

  typedef enum logic {
    ReqCore = 1'b0,
    ReqTrap = 1'b1
  } requester_t;

  localparam logic [1:0]  CSR_RO_PREFIX  = 2'b11;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;

endpackage

// File: rtl/csr_arbiter.sv
// Two-requester grant (fixed trap priority or round-robin) with last_grant tracking.
module csr_arbiter
  import csr_pkg::*;
#(
  parameter int unsigned TRAP_PRIO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic core_valid,
  input  logic trap_valid,
  output logic core_gnt,
  output logic trap_gnt
);

  requester_t last_grant_q, last_grant_d;

  always_comb begin
    core_gnt     = 1'b0;
    trap_gnt     = 1'b0;
    last_grant_d = last_grant_q;
    if (en) begin
      if (core_valid && trap_valid) begin
        if ((TRAP_PRIO != 0) || (last_grant_q == ReqCore)) begin
          trap_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_valid;
        trap_gnt = trap_valid;
      end
      if (trap_gnt) begin
        last_grant_d = ReqTrap;
      end else if (core_gnt) begin
        last_grant_d = ReqCore;
      end
    end
  end

  // Reset to TRAP so the core wins the first round-robin tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ReqTrap;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Read-modify-write sequencer for the shared CSR file port, arbitrating core and trap requests.
// Optional privilege check on core requests is enabled by defining CSR_PRIV_CHECK_EN.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned TRAP_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CSR_PRIV_CHECK_EN
  input  logic [1:0]        priv,
`endif
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [1:0]        core_req_op,
  input  logic [ADDR_W-1:0] core_req_sel,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  output logic              core_rsp_illegal,
  input  logic              trap_req_valid,
  output logic              trap_req_ready,
  input  logic [ADDR_W-1:0] trap_req_sel,
  input  logic [DATA_W-1:0] trap_req_wdata,
  output logic              trap_rsp_valid,
  output logic [ADDR_W-1:0] csr_sel,
  output logic [DATA_W-1:0] csr_wdata,
  output logic              csr_wen,
  input  logic [DATA_W-1:0] csr_rdata
);

  ctrl_state_t       state_q, state_d;
  csr_op_t           op_q, op_d;
  requester_t        owner_q, owner_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic              illegal_q, illegal_d;

  logic              core_gnt, trap_gnt;
  logic [DATA_W-1:0] new_val;
  logic              illegal_now;
  logic              no_write;

  csr_arbiter #(
    .TRAP_PRIO (TRAP_PRIO)
  ) u_arbiter (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == StIdle),
    .core_valid (core_req_valid),
    .trap_valid (trap_req_valid),
    .core_gnt   (core_gnt),
    .trap_gnt   (trap_gnt)
  );

  always_comb begin
    unique case (op_q)
      OpRs:    new_val = csr_rdata | wdata_q;
      OpRc:    new_val = csr_rdata & ~wdata_q;
      default: new_val = wdata_q;
    endcase

    illegal_now = (op_q != OpRead) && (sel_q[ADDR_W-1 -: 2] == CSR_RO_PREFIX);
`ifdef CSR_PRIV_CHECK_EN
    // Trap writes run at machine level and skip the privilege check.
    if ((owner_q == ReqCore) && (sel_q[ADDR_W-3 -: 2] > priv)) begin
      illegal_now = 1'b1;
    end
`endif
    no_write = illegal_now || (op_q == OpRead) ||
               (((op_q == OpRs) || (op_q == OpRc)) && (wdata_q == '0));
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    owner_d   = owner_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    illegal_d = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (core_gnt) begin
          op_d      = csr_op_t'(core_req_op);
          owner_d   = ReqCore;
          sel_d     = core_req_sel;
          wdata_d   = core_req_wdata;
          illegal_d = 1'b0;
          state_d   = StRead;
        end else if (trap_gnt) begin
          op_d      = OpRw;
          owner_d   = ReqTrap;
          sel_d     = trap_req_sel;
          wdata_d   = trap_req_wdata;
          illegal_d = 1'b0;
          state_d   = StRead;
        end
      end
      StRead: begin
        old_d     = csr_rdata;
        illegal_d = illegal_now;
        // wdata_q now carries the modified value for the write cycle.
        wdata_d   = new_val;
        state_d   = no_write ? StResp : StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= OpRead;
      owner_q   <= ReqCore;
      sel_q     <= '0;
      wdata_q   <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  assign core_req_ready   = core_gnt;
  assign trap_req_ready   = trap_gnt;
  assign csr_sel          = sel_q;
  assign csr_wen          = (state_q == StWrite);
  assign csr_wdata        = csr_wen ? wdata_q : '0;
  assign core_rsp_valid   = (state_q == StResp) && (owner_q == ReqCore);
  assign trap_rsp_valid   = (state_q == StResp) && (owner_q == ReqTrap);
  assign core_rsp_rdata   = core_rsp_valid ? old_q : '0;
  assign core_rsp_illegal = core_rsp_valid && illegal_q;

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Sequencer and arbiter for the core's 4096x32 CSR file, which has a single select/write port, combinational read and a negedge write.
- Accepts CSR operations from two requesters: the core execute stage (CSRRW/CSRRS/CSRRC/read) and the trap unit (mepc/mcause/mtval writes).
- Performs read-modify-write on the shared port, suppresses illegal and no-op writes, and returns the old CSR value.

Parameters:
DATA_W, 32, CSR data width
ADDR_W, 12, CSR address width
TRAP_PRIO, 1, 1: trap requester always wins; 0: round-robin between core and trap

Ports:
clk  in  1  clock, rising-edge logic
rst  in  1  asynchronous, active-low reset
core_req_valid  in  1  core request present
core_req_ready  out  1  core request accepted this cycle
core_req_op  in  2  csr_op_t: 00 READ, 01 RW, 10 RS (set), 11 RC (clear)
core_req_sel  in  ADDR_W  CSR address
core_req_wdata  in  DATA_W  source operand (rs1 or zimm, already extended)
core_rsp_valid  out  1  one-cycle response pulse
core_rsp_rdata  out  DATA_W  CSR value before modification
core_rsp_illegal  out  1  write to read-only CSR, qualified by rsp_valid
trap_req_valid  in  1  trap write request (op is always RW)
trap_req_ready  out  1  trap request accepted
trap_req_sel  in  ADDR_W  CSR address
trap_req_wdata  in  DATA_W  value to write
trap_rsp_valid  out  1  one-cycle completion pulse
csr_sel  out  ADDR_W  to CSR file select
csr_wdata  out  DATA_W  to CSR file write data
csr_wen  out  1  to CSR file write enable
csr_rdata  in  DATA_W  from CSR file read data

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset state: IDLE.
- Reset values: all outputs 0; last_grant = TRAP, so the core wins the first round-robin tie.
- Ready is combinational and asserted only in IDLE, to exactly one requester:
  - valid-only requester wins.
  - Both valid: trap wins if TRAP_PRIO=1; otherwise the requester not in last_grant.
- On accept: latch op, sel, wdata and owner; update last_grant; go to READ. Trap requests latch op=RW.
- READ:
  - csr_sel = latched sel; capture csr_rdata into old_q.
  - new = wdata (RW), old|wdata (RS), old&~wdata (RC).
  - illegal = op≠READ && sel[11:10]==2'b11.
  - If illegal, op==READ, or (RS/RC && wdata==0): go to RESP with no write.
  - Otherwise go to WRITE. RW with wdata==0 still writes.
- WRITE:
  - csr_wen=1 for exactly this cycle; csr_sel and csr_wdata stable for the whole cycle, which covers the CSR file's negedge write.
  - Next state: RESP.
- RESP: owner's rsp_valid=1 for one cycle; core_rsp_rdata=old_q; core_rsp_illegal per READ decision. Next state: IDLE.
- Latency, accept edge to rsp_valid: 3 cycles with a write, 2 without. Throughput: one op per 4 cycles (3 if no write).
- No response backpressure; requesters must sample the pulse.
- csr_sel holds the last latched sel outside active states.
- csr_wen=0 in every state except WRITE.
- Reset asserted mid-operation: immediate return to IDLE, csr_wen drops asynchronously, pending op discarded, no response issued.
- Illegal trap write: trap unit never targets read-only CSRs; if it does, the write is dropped and trap_rsp_valid still pulses.

Optional Feature:
CSR_PRIV_CHECK_EN
- Defined:
  - Adds input priv [1:0] (current privilege).
  - Core requests with sel[9:8] > priv are flagged illegal, with no write, even for READ.
  - Trap requests are exempt.
- Undefined: no priv port; only the read-only check applies.

Decomposition:
- Package csr_pkg:
  - csr_op_t enum (READ/RW/RS/RC).
  - ctrl state enum.
  - requester_t {CORE, TRAP}.
  - CSR_RO_PREFIX = 2'b11.
  - Address constants for MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MCYCLE 0xB00, MVENDORID 0xF11.
- Sub-module csr_arbiter: two-requester fixed/round-robin grant plus last_grant register.

Test Plan:
- CSR[0x300]=0x8; core RS sel=0x300 wdata=0x3 -> rsp_rdata=0x8 at accept+3; csr_wen one cycle with wdata=0xB; CSR[0x300]=0xB.
- core RC sel=0x300 wdata=0x0 -> no csr_wen, rsp at accept+2 with rdata=current value.
- core RW sel=0xF11 wdata=0x1 -> rsp_illegal=1, csr_wen never asserted, CSR unchanged.
- Same-cycle core RW 0x341 and trap RW 0x342, TRAP_PRIO=1 -> trap granted first, core granted in next IDLE; with TRAP_PRIO=0 after reset -> core granted first, then trap.
- rst driven low during WRITE -> csr_wen falls immediately, no rsp_valid, FSM in IDLE with all outputs 0 after release.
- CSR_PRIV_CHECK_EN, priv=0, core READ sel=0x300 -> rsp_illegal=1; same with priv=3 -> legal, rdata returned.
